// File: rtl/tdc_hit_scheduler.sv
// tdc_hit_scheduler
// Collects hit words from NCH TDC encoder channels into one-entry holding
// registers and drains them round-robin onto a single valid/ready stream.
// Encoders cannot be stalled, so a strobe that finds its holding register
// occupied (and not being drained that same cycle) is dropped and counted.

module tdc_hit_scheduler #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NCH-1:0]       chEnable,
    input  logic [NCH-1:0]       hitStrobe,
    input  logic [32*NCH-1:0]    hitData,
    input  logic                 outReady,
    input  logic                 clearDrop,
    output logic                 outValid,
    output logic [32+CHW-1:0]    outData,
    output logic [NCH-1:0]       hitPending,
    output logic [7:0]           dropCount,
    output logic                 dropFlag
);

    logic [31:0]        hold_q [NCH];
    logic [NCH-1:0]     pend_q;
    logic [NCH-1:0]     pend_d;
    logic [NCH-1:0]     grant_vec;
    logic [NCH-1:0]     accept_vec;
    logic [NCH-1:0]     drop_vec;
    logic               out_free;
    logic               grant_any;
    logic [CHW-1:0]     grant_idx;
    logic [CHW:0]       scan_idx;
    logic [CHW-1:0]     rr_ptr_q;
    logic [CHW-1:0]     rr_ptr_d;
    logic               out_valid_q;
    logic [32+CHW-1:0]  out_data_q;
    logic [7:0]         drop_cnt_q;
    logic [7:0]         drop_cnt_d;
    logic               drop_flag_q;
    logic               drop_flag_d;
    logic [8:0]         drop_sum;

    // The output register can take a new word when empty or being consumed.
    assign out_free = !out_valid_q || outReady;

    // Rotating-priority search: first pending channel at or above rr_ptr, wrapping.
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan_idx  = '0;
        if (out_free) begin
            for (int k = 0; k < NCH; k++) begin
                scan_idx = {1'b0, rr_ptr_q} + (CHW+1)'(k);
                if (scan_idx >= (CHW+1)'(NCH)) begin
                    scan_idx = scan_idx - (CHW+1)'(NCH);
                end
                if (!grant_any && pend_q[scan_idx[CHW-1:0]]) begin
                    grant_any                      = 1'b1;
                    grant_idx                      = scan_idx[CHW-1:0];
                    grant_vec[scan_idx[CHW-1:0]]   = 1'b1;
                end
            end
        end
    end

    // Per-channel accept/drop decision. A register being granted this cycle
    // is effectively empty, so a simultaneous strobe refills it.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic hit_valid;
        assign hit_valid      = hitStrobe[gi] & chEnable[gi];
        assign accept_vec[gi] = hit_valid & (~pend_q[gi] | grant_vec[gi]);
        assign drop_vec[gi]   = hit_valid & pend_q[gi] & ~grant_vec[gi];
    end

    // Pending flags: granted channels clear, accepted strobes set (set wins).
    always_comb begin
        pend_d = (pend_q & ~grant_vec) | accept_vec;
    end

    // Pointer moves just past the granted channel.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            if (grant_idx == CHW'(NCH - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + CHW'(1);
            end
        end
    end

    // Drop accounting: add this cycle's drops with saturation; clear wins.
    always_comb begin
        drop_sum = {1'b0, drop_cnt_q};
        for (int i = 0; i < NCH; i++) begin
            drop_sum = drop_sum + {8'd0, drop_vec[i]};
        end
        drop_cnt_d  = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
        drop_flag_d = drop_flag_q | (|drop_vec);
        if (clearDrop) begin
            drop_cnt_d  = '0;
            drop_flag_d = 1'b0;
        end
    end

    // Holding registers capture the channel slice on an accepted strobe.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (Reset) begin
                hold_q[i] <= '0;
            end else if (accept_vec[i]) begin
                hold_q[i] <= hitData[32*i +: 32];
            end
        end
    end

    // Pending flags, arbitration pointer and drop statistics.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend_q      <= '0;
            rr_ptr_q    <= '0;
            drop_cnt_q  <= '0;
            drop_flag_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            rr_ptr_q    <= rr_ptr_d;
            drop_cnt_q  <= drop_cnt_d;
            drop_flag_q <= drop_flag_d;
        end
    end

    // Output register: load on grant, empty when consumed with nothing to grant,
    // otherwise hold stable under backpressure.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (grant_any) begin
            out_valid_q <= 1'b1;
            out_data_q  <= {grant_idx, hold_q[grant_idx]};
        end else if (out_free) begin
            out_valid_q <= 1'b0;
        end
    end

    assign outValid   = out_valid_q;
    assign outData    = out_data_q;
    assign hitPending = pend_q;
    assign dropCount  = drop_cnt_q;
    assign dropFlag   = drop_flag_q;

endmodule

// File: tb/tb_tdc_hit_scheduler.sv
// Self-checking bench for tdc_hit_scheduler: directed scenarios with constant
// expectations plus a randomized run against a transaction-level model.

module tb_tdc_hit_scheduler;

    localparam int NCH = 4;
    localparam int CHW = 2;

    logic                Clk = 1'b0;
    logic                Reset;
    logic [NCH-1:0]      chEnable;
    logic [NCH-1:0]      hitStrobe;
    logic [32*NCH-1:0]   hitData;
    logic                outReady;
    logic                clearDrop;
    logic                outValid;
    logic [32+CHW-1:0]   outData;
    logic [NCH-1:0]      hitPending;
    logic [7:0]          dropCount;
    logic                dropFlag;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0]         m_hold [NCH];
    logic [NCH-1:0]      m_pend;
    logic                m_ov;
    logic [32+CHW-1:0]   m_od;
    int                  m_ptr;
    int                  m_cnt;
    logic                m_flag;

    tdc_hit_scheduler #(.NCH(NCH), .CHW(CHW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .chEnable   (chEnable),
        .hitStrobe  (hitStrobe),
        .hitData    (hitData),
        .outReady   (outReady),
        .clearDrop  (clearDrop),
        .outValid   (outValid),
        .outData    (outData),
        .hitPending (hitPending),
        .dropCount  (dropCount),
        .dropFlag   (dropFlag)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; the model decides from the inputs held before the edge.
    task automatic tick();
        logic            free;
        int              g;
        int              nd;
        logic [NCH-1:0]  acc;
        free = !m_ov || outReady;
        g    = -1;
        if (free) begin
            for (int k = 0; k < NCH; k++) begin
                if (g < 0 && m_pend[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
            end
        end
        nd  = 0;
        acc = '0;
        for (int i = 0; i < NCH; i++) begin
            if (hitStrobe[i] && chEnable[i]) begin
                if (!m_pend[i] || i == g) acc[i] = 1'b1;
                else nd++;
            end
        end
        @(posedge Clk);
        #1;
        if (Reset) begin
            for (int i = 0; i < NCH; i++) m_hold[i] = '0;
            m_pend = '0; m_ov = 1'b0; m_od = '0; m_ptr = 0; m_cnt = 0; m_flag = 1'b0;
        end else begin
            if (g >= 0) begin
                m_od      = {CHW'(g), m_hold[g]};
                m_ov      = 1'b1;
                m_pend[g] = 1'b0;
                m_ptr     = (g + 1) % NCH;
            end else if (free) begin
                m_ov = 1'b0;
            end
            for (int i = 0; i < NCH; i++) begin
                if (acc[i]) begin
                    m_hold[i] = hitData[32*i +: 32];
                    m_pend[i] = 1'b1;
                end
            end
            if (clearDrop) begin
                m_cnt  = 0;
                m_flag = 1'b0;
            end else begin
                m_cnt = (m_cnt + nd > 255) ? 255 : m_cnt + nd;
                if (nd > 0) m_flag = 1'b1;
            end
        end
    endtask

    task automatic set_hit(input int ch, input logic [31:0] d);
        hitStrobe[ch]        = 1'b1;
        hitData[32*ch +: 32] = d;
    endtask

    task automatic clear_hits();
        hitStrobe = '0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        clear_hits();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got=%b exp=0", outValid); end
        checks++; if (outData !== '0) begin errors++; $display("FAIL reset_outData got=%h exp=0", outData); end
        checks++; if (hitPending !== '0) begin errors++; $display("FAIL reset_hitPending got=%b exp=0", hitPending); end
        checks++; if (dropCount !== 8'd0) begin errors++; $display("FAIL reset_dropCount got=%0d exp=0", dropCount); end
        checks++; if (dropFlag !== 1'b0) begin errors++; $display("FAIL reset_dropFlag got=%b exp=0", dropFlag); end
        $display("test_reset done");
    endtask

    task automatic test_single_hit();
        do_reset();
        outReady = 1'b1; chEnable = '1;
        set_hit(2, 32'h1234_5678);
        tick(); clear_hits();
        checks++; if (hitPending !== 4'b0100) begin errors++; $display("FAIL single_pend got=%b exp=0100", hitPending); end
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", outValid); end
        tick();
        checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", outValid); end
        checks++; if (outData !== {2'd2, 32'h1234_5678}) begin errors++; $display("FAIL single_data got=%h exp=%h", outData, {2'd2, 32'h1234_5678}); end
        $display("single_hit word ch=%0d data=%h", outData[33:32], outData[31:0]);
        tick();
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL single_one_cycle got=%b exp=0", outValid); end
        checks++; if (hitPending !== 4'b0000) begin errors++; $display("FAIL single_pend_clr got=%b exp=0000", hitPending); end
    endtask

    task automatic test_round_robin();
        logic [CHW-1:0] exp_ch;
        do_reset();
        outReady = 1'b1; chEnable = '1;
        for (int i = 0; i < NCH; i++) set_hit(i, 32'hA000_0000 + 32'(i));
        tick(); clear_hits();
        checks++; if (hitPending !== 4'b1111) begin errors++; $display("FAIL rr_pend got=%b exp=1111", hitPending); end
        for (int k = 0; k < NCH; k++) begin
            tick();
            exp_ch = CHW'(k);
            checks++; if (outValid !== 1'b1 || outData !== {exp_ch, 32'hA000_0000 + 32'(k)}) begin
                errors++; $display("FAIL rr_order0 step=%0d got=%b/%h exp=1/%h", k, outValid, outData, {exp_ch, 32'hA000_0000 + 32'(k)});
            end
            $display("rr pass0 word ch=%0d data=%h", outData[33:32], outData[31:0]);
        end
        // one grant on ch0 moves the pointer to 1
        set_hit(0, 32'h5555_0000);
        tick(); clear_hits();
        tick();
        for (int i = 0; i < NCH; i++) set_hit(i, 32'hB000_0000 + 32'(i));
        tick(); clear_hits();
        for (int k = 0; k < NCH; k++) begin
            tick();
            exp_ch = CHW'((1 + k) % NCH);
            checks++; if (outValid !== 1'b1 || outData !== {exp_ch, 32'hB000_0000 + 32'((1 + k) % NCH)}) begin
                errors++; $display("FAIL rr_order1 step=%0d got=%b/%h exp=1/%h", k, outValid, outData, {exp_ch, 32'hB000_0000 + 32'((1 + k) % NCH)});
            end
            $display("rr pass1 word ch=%0d data=%h", outData[33:32], outData[31:0]);
        end
        tick();
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL rr_idle got=%b exp=0", outValid); end
    endtask

    task automatic test_backpressure();
        int stable_bad;
        do_reset();
        outReady = 1'b0; chEnable = '1;
        set_hit(1, 32'hBEEF_0001);
        tick(); clear_hits();
        tick();
        checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL bp_valid got=%b exp=1", outValid); end
        stable_bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (outValid !== 1'b1 || outData !== {2'd1, 32'hBEEF_0001}) stable_bad++;
        end
        checks++; if (stable_bad != 0) begin errors++; $display("FAIL bp_stable bad_cycles=%0d exp=0 last=%b/%h", stable_bad, outValid, outData); end
        outReady = 1'b1;
        $display("bp word ch=%0d data=%h", outData[33:32], outData[31:0]);
        tick();
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL bp_delivered got=%b exp=0", outValid); end
    endtask

    task automatic test_overflow();
        do_reset();
        outReady = 1'b0; chEnable = '1;
        set_hit(0, 32'h0000_00C0);
        tick(); clear_hits();
        tick();
        set_hit(3, 32'hAAAA_0001); tick();
        set_hit(3, 32'hAAAA_0002); tick();
        set_hit(3, 32'hAAAA_0003); tick();
        clear_hits();
        checks++; if (hitPending !== 4'b1000) begin errors++; $display("FAIL ovf_pend got=%b exp=1000", hitPending); end
        checks++; if (dropCount !== 8'd2) begin errors++; $display("FAIL ovf_count got=%0d exp=2", dropCount); end
        checks++; if (dropFlag !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", dropFlag); end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        checks++; if (outData !== {2'd3, 32'hAAAA_0001}) begin errors++; $display("FAIL ovf_first_word got=%h exp=%h", outData, {2'd3, 32'hAAAA_0001}); end
        $display("ovf word ch=%0d data=%h", outData[33:32], outData[31:0]);
        set_hit(2, 32'hDDDD_0000);
        tick();
        for (int i = 0; i < 300; i++) begin
            hitData[64 +: 32] = $urandom;
            tick();
            if (i == 251) begin
                checks++; if (dropCount !== 8'd254) begin errors++; $display("FAIL ovf_254 got=%0d exp=254", dropCount); end
            end
        end
        checks++; if (dropCount !== 8'd255) begin errors++; $display("FAIL ovf_sat got=%0d exp=255", dropCount); end
        clearDrop = 1'b1;
        tick();
        clearDrop = 1'b0;
        clear_hits();
        checks++; if (dropCount !== 8'd0 || dropFlag !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0d/%b exp=0/0", dropCount, dropFlag); end
        outReady = 1'b1;
        tick();
        checks++; if (outData !== {2'd2, 32'hDDDD_0000}) begin errors++; $display("FAIL ovf_kept_word got=%h exp=%h", outData, {2'd2, 32'hDDDD_0000}); end
        tick();
    endtask

    task automatic test_mask_disable();
        int bad;
        do_reset();
        outReady = 1'b1; chEnable = 4'b1110;
        set_hit(0, 32'h0BAD_0000);
        tick(); clear_hits();
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            if (outValid !== 1'b0 || hitPending !== 4'b0000) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mask_ignored bad_cycles=%0d exp=0", bad); end
        checks++; if (dropCount !== 8'd0) begin errors++; $display("FAIL mask_nodrop got=%0d exp=0", dropCount); end
        chEnable = '1; outReady = 1'b0;
        set_hit(2, 32'hEEEE_0002);
        tick(); clear_hits();
        tick();
        set_hit(1, 32'hF00D_0001);
        tick(); clear_hits();
        chEnable = 4'b1100;
        set_hit(1, 32'h1111_1111);
        tick(); clear_hits();
        checks++; if (hitPending !== 4'b0010 || dropCount !== 8'd0) begin errors++; $display("FAIL dis_pend got=%b/%0d exp=0010/0", hitPending, dropCount); end
        outReady = 1'b1;
        tick();
        checks++; if (outValid !== 1'b1 || outData !== {2'd1, 32'hF00D_0001}) begin errors++; $display("FAIL dis_drain got=%b/%h exp=1/%h", outValid, outData, {2'd1, 32'hF00D_0001}); end
        $display("dis word ch=%0d data=%h", outData[33:32], outData[31:0]);
        tick();
        chEnable = '1;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        outReady = 1'b0; chEnable = '1;
        set_hit(0, 32'hC0C0_0000);
        tick(); clear_hits();
        tick();
        set_hit(1, 32'h1); set_hit(2, 32'h2); set_hit(3, 32'h3);
        tick(); clear_hits();
        checks++; if (hitPending !== 4'b1110 || outValid !== 1'b1) begin errors++; $display("FAIL rst_setup got=%b/%b exp=1110/1", hitPending, outValid); end
        set_hit(1, 32'h11);
        tick(); clear_hits();
        checks++; if (dropCount !== 8'd1) begin errors++; $display("FAIL rst_predrop got=%0d exp=1", dropCount); end
        Reset = 1'b1;
        set_hit(2, 32'h22);
        tick();
        Reset = 1'b0; clear_hits();
        checks++; if (outValid !== 1'b0 || hitPending !== 4'b0000 || dropCount !== 8'd0 || dropFlag !== 1'b0) begin
            errors++; $display("FAIL rst_mid got=%b/%b/%0d/%b exp=0/0000/0/0", outValid, hitPending, dropCount, dropFlag);
        end
        outReady = 1'b1;
        set_hit(0, 32'h0000_AAAA); set_hit(3, 32'h0000_3333);
        tick(); clear_hits();
        tick();
        checks++; if (outData !== {2'd0, 32'h0000_AAAA} || outValid !== 1'b1) begin errors++; $display("FAIL rst_ptr0 got=%b/%h exp=1/%h", outValid, outData, {2'd0, 32'h0000_AAAA}); end
        tick();
        checks++; if (outData !== {2'd3, 32'h0000_3333} || outValid !== 1'b1) begin errors++; $display("FAIL rst_ptr3 got=%b/%h exp=1/%h", outValid, outData, {2'd3, 32'h0000_3333}); end
        tick();
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            chEnable  = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
            for (int i = 0; i < NCH; i++) begin
                hitStrobe[i]        = ($urandom_range(0, 9) < 3);
                hitData[32*i +: 32] = $urandom;
            end
            outReady  = ($urandom_range(0, 3) != 0);
            clearDrop = ($urandom_range(0, 40) == 0);
            Reset     = ($urandom_range(0, 120) == 0);
            if (m_ov && outReady && !Reset) $display("rand xfer ch=%0d data=%h", m_od[33:32], m_od[31:0]);
            tick();
            checks++; if (outValid !== m_ov) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, outValid, m_ov); end
            checks++; if (m_ov && outData !== m_od) begin errors++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, outData, m_od); end
            checks++; if (hitPending !== m_pend) begin errors++; $display("FAIL rand_pend cyc=%0d got=%b exp=%b", c, hitPending, m_pend); end
            checks++; if (dropCount !== 8'(m_cnt)) begin errors++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, dropCount, m_cnt); end
            checks++; if (dropFlag !== m_flag) begin errors++; $display("FAIL rand_flag cyc=%0d got=%b exp=%b", c, dropFlag, m_flag); end
        end
        Reset = 1'b0; clearDrop = 1'b0; clear_hits();
    endtask

    initial begin
        Reset = 1'b1; chEnable = '1; hitStrobe = '0; hitData = '0;
        outReady = 1'b1; clearDrop = 1'b0;
        for (int i = 0; i < NCH; i++) m_hold[i] = '0;
        m_pend = '0; m_ov = 1'b0; m_od = '0; m_ptr = 0; m_cnt = 0; m_flag = 1'b0;
        test_reset();
        test_single_hit();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_mask_disable();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
